mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum cycles spent in REQ waiting for dmem_ack before the access is aborted.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 start  in  1  execution stage presents an access; qualifies addr, wdata, mem_read, mem_write and funct3.
REQ-005 addr  in  32  byte address (ALU result).
REQ-006 wdata  in  32  store data (second register operand).
REQ-007 mem_read, mem_write  in  1 each  load or store request.
REQ-008 funct3  in  3  access size and sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-009 busy  out  1  stall to the pipeline; high whenever state is not IDLE.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 rdata  out  32  load result, held until the next completed load.
REQ-012 fault  out  1  error flag for the last access, held until the next accepted start.
REQ-013 dmem_req, dmem_we  out  1 each; dmem_addr  out  32; dmem_wdata  out  32; dmem_be  out  4  data-memory request bus.
REQ-014 dmem_rdata  in  32; dmem_ack  in  1  data-memory response.

Function
REQ-015 FSM states SHALL be IDLE, REQ and DONE; start SHALL be accepted only in IDLE and SHALL be ignored otherwise.
REQ-016 On accept, the block SHALL register addr, wdata, funct3 and the operation type, and clear fault.
REQ-017 Start with mem_read=0 and mem_write=0 SHALL go to DONE with no memory request and leave rdata unchanged.
REQ-018 Start with mem_read=1 and mem_write=1, or with funct3 in {011,110,111}, SHALL set fault and go to DONE with no request.
REQ-019 A valid access SHALL enter REQ; dmem_req=1 from the next cycle, with dmem_we equal to the registered mem_write and dmem_addr equal to {addr[31:2],2'b00}.
REQ-020 All dmem_* outputs SHALL remain stable while in REQ until dmem_ack is sampled high.
REQ-021 dmem_be: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<(2*addr[1]); word = 4'b1111.
REQ-022 dmem_wdata: the low byte replicated to all four lanes for byte stores, the low half replicated to both halves for half stores, wdata unchanged for word stores.
REQ-023 When dmem_ack=1 in REQ: loads SHALL capture rdata = dmem_rdata shifted right by 8*addr[1:0] (or by 16*addr[1] for halfwords), then sign-extended (000/001) or zero-extended (100/101); state goes to DONE.
REQ-024 dmem_ack outside REQ SHALL be ignored.
REQ-025 A counter SHALL count cycles in REQ; if it reaches TIMEOUT_CYCLES without ack, the block SHALL set fault, drop dmem_req and go to DONE.
REQ-026 DONE SHALL last one cycle with done=1, then return to IDLE. Latency: start at cycle 0, req from cycle 1, ack at cycle k, done at cycle k+1, busy low at cycle k+2.

Reset
REQ-027 rst SHALL immediately force IDLE and zero busy, done, rdata, fault, all dmem_* outputs and the timeout counter.
REQ-028 A reset during REQ SHALL abort the transaction; a later ack SHALL be ignored.

Configuration
REQ-029 Macro MISALIGN_TRAP_EN defined: a halfword access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL set fault and go to DONE with no request.
REQ-030 MISALIGN_TRAP_EN undefined: misalignment SHALL never fault; the excess low address bits are ignored (word uses lane offset 0, halfword uses addr[1] only).

Verification
REQ-031 SW addr=0x100, wdata=0xDEADBEEF, ack at cycle 3 -> dmem_be=1111, dmem_addr=0x100, done at cycle 4, fault=0.
REQ-032 LB addr=0x103, dmem_rdata=0x80112233 -> rdata=0xFFFFFF80; LBU at the same address -> rdata=0x00000080.
REQ-033 SH addr=0x102, wdata=0x0000ABCD -> dmem_be=1100, dmem_wdata=0xABCDABCD.
REQ-034 LW with ack never asserted, TIMEOUT_CYCLES=4 -> done with fault=1 four cycles after dmem_req rises; dmem_req low afterwards.
REQ-035 LW addr=0x101 -> with MISALIGN_TRAP_EN: fault=1, done at cycle 1, no dmem_req; without it: dmem_addr=0x100, normal load.
REQ-036 rst pulse in the middle of REQ, then ack -> dmem_req low immediately, busy=0, no done pulse, rdata=0.

Source files
------------

// File: rtl/mem_access_if.sv
// Pipeline-side request/response and data-memory bus signals for mem_access.
interface mem_access_if;
  logic        start;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        fault;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport slave (
    input  start, addr, wdata, mem_read, mem_write, funct3, dmem_rdata, dmem_ack,
    output busy, done, rdata, fault, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be
  );

  modport master (
    output start, addr, wdata, mem_read, mem_write, funct3, dmem_rdata, dmem_ack,
    input  busy, done, rdata, fault, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be
  );
endinterface

// File: rtl/mem_access.sv
// Load/store unit: IDLE/REQ/DONE sequencer between the execute stage and data memory.
// Optional macro MISALIGN_TRAP_EN turns misaligned half/word accesses into faults.
module mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic          clk,
  input logic          rst,
  mem_access_if.slave  bus
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              fault_q, fault_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       dmem_addr_q, dmem_addr_d;
  logic [31:0]       dmem_wdata_q, dmem_wdata_d;
  logic [3:0]        dmem_be_q, dmem_be_d;

  logic              bad_op;
  logic              misaligned;
  logic [3:0]        be_calc;
  logic [31:0]       wdata_calc;
  logic [31:0]       shifted;
  logic [31:0]       load_val;

  assign bad_op = (bus.mem_read && bus.mem_write) ||
                  (bus.funct3 inside {3'b011, 3'b110, 3'b111});

`ifdef MISALIGN_TRAP_EN
  assign misaligned = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                      ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Byte enables and lane-replicated store data, computed from the incoming request.
  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = bus.wdata;
    unique case (bus.funct3[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << bus.addr[1:0];
        wdata_calc = {4{bus.wdata[7:0]}};
      end
      2'b01: begin
        be_calc    = bus.addr[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{bus.wdata[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = bus.wdata;
      end
    endcase
  end

  always_comb begin
    shifted  = bus.dmem_rdata;
    load_val = bus.dmem_rdata;
    unique case (funct3_q[1:0])
      2'b00:   shifted = bus.dmem_rdata >> {addr_lo_q, 3'b000};
      2'b01:   shifted = bus.dmem_rdata >> {addr_lo_q[1], 4'b0000};
      default: shifted = bus.dmem_rdata;
    endcase
    unique case (funct3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_val = {24'h0, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_val = {16'h0, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_lo_d    = addr_lo_q;
    funct3_d     = funct3_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    rdata_d      = rdata_q;
    fault_d      = fault_q;
    req_d        = req_q;
    we_d         = we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_be_d    = dmem_be_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          addr_lo_d = bus.addr[1:0];
          funct3_d  = bus.funct3;
          fault_d   = 1'b0;
          busy_d    = 1'b1;
          cnt_d     = '0;
          if (!bus.mem_read && !bus.mem_write) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else if (bad_op || misaligned) begin
            fault_d = 1'b1;
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d      = StReq;
            req_d        = 1'b1;
            we_d         = bus.mem_write;
            dmem_addr_d  = {bus.addr[31:2], 2'b00};
            dmem_be_d    = be_calc;
            dmem_wdata_d = wdata_calc;
          end
        end
      end
      StReq: begin
        if (bus.dmem_ack) begin
          if (!we_q) rdata_d = load_val;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = StDone;
          done_d  = 1'b1;
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          fault_d = 1'b1;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      addr_lo_q    <= 2'b00;
      funct3_q     <= 3'b000;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rdata_q      <= 32'h0;
      fault_q      <= 1'b0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      dmem_addr_q  <= 32'h0;
      dmem_wdata_q <= 32'h0;
      dmem_be_q    <= 4'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_lo_q    <= addr_lo_d;
      funct3_q     <= funct3_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rdata_q      <= rdata_d;
      fault_q      <= fault_d;
      req_q        <= req_d;
      we_q         <= we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_be_q    <= dmem_be_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.rdata      = rdata_q;
  assign bus.fault      = fault_q;
  assign bus.dmem_req   = req_q;
  assign bus.dmem_we    = we_q;
  assign bus.dmem_addr  = dmem_addr_q;
  assign bus.dmem_wdata = dmem_wdata_q;
  assign bus.dmem_be    = dmem_be_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases, randomized accesses against a reference model.
module tb_mem_access;
  localparam int unsigned T = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] model_rdata = 32'h0;
  logic        model_fault = 1'b0;

  mem_access_if bus ();

  mem_access #(.TIMEOUT_CYCLES(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit ref_misaligned(input logic [2:0] f3, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    int unsigned sz;
    sz = 1 << f3[1:0];
    return (sz == 2 || sz == 4) && ((a % sz) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit ref_fault(input logic rd, input logic wr, input logic [2:0] f3,
                                   input logic [31:0] a);
    if (!rd && !wr) return 1'b0;
    if (rd && wr) return 1'b1;
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
    return ref_misaligned(f3, a);
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
    int unsigned sz;
    int unsigned off;
    sz  = 1 << f3[1:0];
    off = (a % 4) / sz * sz;
    return 4'(((1 << sz) - 1) << off);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] w);
    if (f3[1:0] == 0) return (w & 32'hFF) * 32'h01010101;
    if (f3[1:0] == 1) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] d);
    int unsigned sz;
    int unsigned off;
    logic [31:0] v;
    sz  = 1 << f3[1:0];
    off = (a % 4) / sz * sz;
    if (sz == 4) return d;
    v = (d >> (8 * off)) & ((32'h1 << (8 * sz)) - 1);
    if (f3 < 4 && v >= (32'h1 << (8 * sz - 1))) v = v - (32'h1 << (8 * sz));
    return v;
  endfunction

  // One access from start to the first idle cycle; k = ack cycle (outside 1..T means never).
  task automatic access(input logic [31:0] a, input logic [31:0] w, input logic rd,
                        input logic wr, input logic [2:0] f3, input int k,
                        input logic [31:0] resp, input bit noise);
    bit f;
    bit req;
    bit acked;
    int d;
    f     = ref_fault(rd, wr, f3, a);
    req   = !f && (rd || wr);
    acked = req && (k >= 1) && (k <= int'(T));
    d     = !req ? 1 : (acked ? k + 1 : int'(T) + 1);
    bus.start     = 1'b1;
    bus.addr      = a;
    bus.wdata     = w;
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.funct3    = f3;
    bus.dmem_ack  = 1'b0;
    @(negedge clk);
    for (int c = 1; c < d; c++) begin
      bus.start     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.addr      = $urandom;
      bus.mem_read  = 1'($urandom_range(0, 1));
      bus.mem_write = 1'($urandom_range(0, 1));
      bus.funct3    = 3'($urandom_range(0, 7));
      chk("req_high", 32'(bus.dmem_req), 32'd1);
      chk("req_we", 32'(bus.dmem_we), 32'(wr));
      chk("req_addr", bus.dmem_addr, a & 32'hFFFF_FFFC);
      chk("req_be", 32'(bus.dmem_be), 32'(ref_be(f3, a)));
      if (wr) chk("req_wdata", bus.dmem_wdata, ref_wdata(f3, w));
      chk("req_busy", 32'(bus.busy), 32'd1);
      chk("req_nodone", 32'(bus.done), 32'd0);
      bus.dmem_ack   = (c == k);
      bus.dmem_rdata = (c == k) ? resp : $urandom;
      @(negedge clk);
    end
    model_fault = f || (req && !acked);
    if (acked && !wr) model_rdata = ref_load(f3, a, resp);
    bus.dmem_ack   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.dmem_rdata = $urandom;
    bus.start      = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("done_fault", 32'(bus.fault), 32'(model_fault));
    chk("done_req_low", 32'(bus.dmem_req), 32'd0);
    chk("done_busy", 32'(bus.busy), 32'd1);
    chk("done_rdata", bus.rdata, model_rdata);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dmem_ack = 1'b0;
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_done", 32'(bus.done), 32'd0);
    chk("idle_req", 32'(bus.dmem_req), 32'd0);
    chk("idle_fault", 32'(bus.fault), 32'(model_fault));
    chk("idle_rdata", bus.rdata, model_rdata);
  endtask

  initial begin
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.addr       = 32'h0;
    bus.wdata      = 32'h0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.funct3     = 3'b000;
    bus.dmem_rdata = 32'h0;
    bus.dmem_ack   = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_fault", 32'(bus.fault), 32'd0);
    chk("rst_req", 32'(bus.dmem_req), 32'd0);
    chk("rst_we", 32'(bus.dmem_we), 32'd0);
    chk("rst_addr", bus.dmem_addr, 32'h0);
    chk("rst_wdata", bus.dmem_wdata, 32'h0);
    chk("rst_be", 32'(bus.dmem_be), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    access(32'h100, 32'hDEADBEEF, 1'b0, 1'b1, 3'b010, 3, 32'h0, 1'b0);
    access(32'h103, 32'h0, 1'b1, 1'b0, 3'b000, 1, 32'h80112233, 1'b0);
    chk("lb_sign", bus.rdata, 32'hFFFFFF80);
    access(32'h103, 32'h0, 1'b1, 1'b0, 3'b100, 2, 32'h80112233, 1'b0);
    chk("lbu_zero", bus.rdata, 32'h00000080);
    access(32'h102, 32'h0000ABCD, 1'b0, 1'b1, 3'b001, 2, 32'h0, 1'b0);
    access(32'h200, 32'h0, 1'b1, 1'b0, 3'b010, 0, 32'h0, 1'b0);
    chk("timeout_fault", 32'(bus.fault), 32'd1);
    access(32'h101, 32'h0, 1'b1, 1'b0, 3'b010, 1, 32'h12345678, 1'b0);
    access(32'h300, 32'h0, 1'b0, 1'b0, 3'b010, 1, 32'h0, 1'b0);
    access(32'h300, 32'h0, 1'b1, 1'b1, 3'b010, 1, 32'h0, 1'b0);
    access(32'h300, 32'h0, 1'b1, 1'b0, 3'b011, 1, 32'h0, 1'b0);
    access(32'h300, 32'h0, 1'b0, 1'b1, 3'b110, 1, 32'h0, 1'b0);
    access(32'h302, 32'h0, 1'b1, 1'b0, 3'b101, 4, 32'hC3A5_7E11, 1'b0);

    for (int i = 0; i < 80; i++) begin
      access($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)), int'($urandom_range(0, 6)), $urandom, 1'b1);
    end

    // Ack and data arriving while idle must not disturb anything.
    for (int i = 0; i < 3; i++) begin
      bus.dmem_ack   = 1'b1;
      bus.dmem_rdata = $urandom;
      @(negedge clk);
      chk("stray_ack_rdata", bus.rdata, model_rdata);
      chk("stray_ack_done", 32'(bus.done), 32'd0);
      chk("stray_ack_busy", 32'(bus.busy), 32'd0);
    end
    bus.dmem_ack = 1'b0;

    // Reset in the middle of REQ, then a late ack.
    bus.start     = 1'b1;
    bus.addr      = 32'h400;
    bus.mem_read  = 1'b1;
    bus.mem_write = 1'b0;
    bus.funct3    = 3'b010;
    @(negedge clk);
    bus.start = 1'b0;
    chk("rstmid_req_up", 32'(bus.dmem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_rdata = 32'h0;
    model_fault = 1'b0;
    chk("rstmid_req", 32'(bus.dmem_req), 32'd0);
    chk("rstmid_busy", 32'(bus.busy), 32'd0);
    chk("rstmid_rdata", bus.rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.dmem_ack   = 1'b1;
      bus.dmem_rdata = 32'hCAFEF00D;
      @(negedge clk);
      chk("late_ack_done", 32'(bus.done), 32'd0);
      chk("late_ack_busy", 32'(bus.busy), 32'd0);
      chk("late_ack_rdata", bus.rdata, 32'h0);
    end
    bus.dmem_ack = 1'b0;

    access(32'h504, 32'h0, 1'b1, 1'b0, 3'b001, 1, 32'h8001_7FFF, 1'b0);
    chk("after_rst_lh", bus.rdata, 32'h00007FFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
